i2c_cmd_queue: RTL and testbench
================================

I2C_CMD_QUEUE -- requirements
Module: i2c_cmd_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, slave address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles from m_ready to m_valid.
REQ-005 SHALL have parameter MAX_RETRY, default 2, retries per command (used only with I2C_RETRY_EN).
REQ-006 SHALL have the following ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  host command offered.
- cmd_ready  output  1  FIFO can accept.
- cmd_addr  input  ADDR_WIDTH  target slave address.
- cmd_data  input  DATA_WIDTH  write byte.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  host consumes response.
- rsp_data  output  DATA_WIDTH  byte returned by master.
- rsp_error  output  1  NACK or timeout.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  queued commands.
- idle  output  1  FIFO empty, FSM IDLE, no response held.
- m_slave_addr  output  ADDR_WIDTH  to master slave_addr.
- m_tx_data  output  DATA_WIDTH  to master tx_data.
- m_ready  output  1  one-cycle start pulse to master ready.
- m_rx_data  input  DATA_WIDTH  from master rx_data.
- m_valid  input  1  one-cycle completion pulse from master.
- m_busy  input  1  master busy.
- m_ack_error  input  1  master ack_error, sampled when m_valid=1.

Function
REQ-007 SHALL accept a command on any cycle where cmd_valid=1 and cmd_ready=1; cmd_ready=1 iff fifo_count<FIFO_DEPTH.
REQ-008 SHALL keep the FIFO strictly ordered, with wrapping pointers; push and pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full.
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE, RESPOND.
REQ-010 SHALL move IDLE->ISSUE when FIFO non-empty, m_busy=0 and rsp_valid=0; it SHALL pop the head entry into m_slave_addr/m_tx_data in that same transition.
REQ-011 SHALL, in ISSUE, assert m_ready for exactly one cycle, load the timeout counter with 0, and go to WAIT_DONE next cycle.
REQ-012 SHALL hold m_slave_addr/m_tx_data stable from ISSUE until leaving WAIT_DONE.
REQ-013 SHALL, in WAIT_DONE, increment the timeout counter each cycle; on m_valid=1 it SHALL capture m_rx_data and m_ack_error and go to RESPOND.
REQ-014 SHALL, when the counter reaches TIMEOUT_CYCLES-1 without m_valid, set rsp_error=1 and rsp_data=0, and go to RESPOND; m_valid on that same cycle takes priority over the timeout.
REQ-015 SHALL, in RESPOND, assert rsp_valid with rsp_data/rsp_error stable until rsp_ready=1, then return to IDLE; rsp_valid and rsp_ready high in the same cycle SHALL complete the transfer in 1 cycle.
REQ-016 SHALL ignore m_valid outside WAIT_DONE.
REQ-017 SHALL give minimum latency from cmd accept (empty FIFO, idle master) to m_ready of 2 cycles.

Reset
REQ-018 SHALL, with reset=0, immediately clear: FIFO pointers, fifo_count=0, state=IDLE, m_ready=0, m_slave_addr=0, m_tx_data=0, rsp_valid=0, rsp_data=0, rsp_error=0, retry and timeout counters=0; cmd_ready=1, idle=1.
REQ-019 SHALL, on reset mid-transaction, discard all queued and in-flight commands, with no response produced.

Configuration
REQ-020 SHALL, with I2C_RETRY_EN defined, return WAIT_DONE->ISSUE instead of RESPOND when m_ack_error=1 or timeout and retries used < MAX_RETRY, reissuing the same addr/data and incrementing the retry count; the count SHALL clear on each new pop; rsp_error=1 only after MAX_RETRY+1 failed attempts.
REQ-021 SHALL, without I2C_RETRY_EN, report every NACK/timeout immediately in RESPOND; no retry counter logic SHALL exist.

Verification
REQ-022 SHALL check: push {0x50,0xA5}; master pulses m_valid with m_rx_data=0x3C, m_ack_error=0 -> one m_ready pulse with m_slave_addr=0x50, m_tx_data=0xA5; rsp_data=0x3C, rsp_error=0.
REQ-023 SHALL check: push 5 commands with rsp_ready=0, no master completions -> cmd_ready=0 at fifo_count=4; 5th accepted only after a pop; order preserved.
REQ-024 SHALL check: master never pulses m_valid -> rsp_valid with rsp_error=1, rsp_data=0 exactly TIMEOUT_CYCLES cycles after m_ready.
REQ-025 SHALL check: m_ack_error=1 every attempt -> without I2C_RETRY_EN, 1 m_ready pulse and rsp_error=1; with it, 3 m_ready pulses (MAX_RETRY=2), same addr/data, then rsp_error=1.
REQ-026 SHALL check: reset=0 asserted in WAIT_DONE with 2 queued commands -> fifo_count=0, idle=1, m_ready=0 immediately; no rsp_valid after release.
REQ-027 SHALL check: push while full and popping on the same cycle -> fifo_count stays 4, no entry lost or duplicated.

Source files
------------

// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: ordered host command FIFO driving a single-transfer I2C master, with response hold and timeout.
// Build option: define I2C_RETRY_EN to reissue NACKed or timed-out commands up to MAX_RETRY times.
module i2c_cmd_queue #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle,
  output logic [ADDR_WIDTH-1:0]         m_slave_addr,
  output logic [DATA_WIDTH-1:0]         m_tx_data,
  output logic                          m_ready,
  input  logic [DATA_WIDTH-1:0]         m_rx_data,
  input  logic                          m_valid,
  input  logic                          m_busy,
  input  logic                          m_ack_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

  state_t                             state;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]                   wr_ptr;
  logic [PTR_W-1:0]                   rd_ptr;
  logic [TMO_W-1:0]                   tmo_cnt;
  logic [TMO_W-1:0]                   tmo_nxt;
  logic                               tmo_hit;
  logic                               push;
  logic                               pop;
  logic                               attempt_failed;
  logic                               retry_ok;

  assign cmd_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0) && !m_busy && !rsp_valid;
  assign idle      = (fifo_count == '0) && (state == IDLE) && !rsp_valid;

  // The counter never actually stores TIMEOUT_CYCLES-1: the edge that would load it
  // is the edge that leaves WAIT_DONE, so rsp_valid lands TIMEOUT_CYCLES after m_ready.
  assign tmo_nxt = tmo_cnt + 1'b1;
  assign tmo_hit = (tmo_nxt == TMO_LAST);

  assign attempt_failed = m_valid ? m_ack_error : tmo_hit;

`ifdef I2C_RETRY_EN
  localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;
  logic [RTY_W-1:0] retry_cnt;
  assign retry_ok = (retry_cnt < RTY_W'(MAX_RETRY));
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {cmd_addr, cmd_data};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      m_ready      <= 1'b0;
      m_slave_addr <= '0;
      m_tx_data    <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_error    <= 1'b0;
      tmo_cnt      <= '0;
`ifdef I2C_RETRY_EN
      retry_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {m_slave_addr, m_tx_data} <= mem[rd_ptr];
            m_ready                   <= 1'b1;
            state                     <= ISSUE;
`ifdef I2C_RETRY_EN
            retry_cnt                 <= '0;
`endif
          end
        end
        ISSUE: begin
          m_ready <= 1'b0;
          tmo_cnt <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          tmo_cnt <= tmo_nxt;
          if ((m_valid || tmo_hit) && attempt_failed && retry_ok) begin
            // Address and data registers are left untouched so the reissue is identical.
            m_ready <= 1'b1;
            state   <= ISSUE;
`ifdef I2C_RETRY_EN
            retry_cnt <= retry_cnt + 1'b1;
`endif
          end else if (m_valid) begin
            rsp_data  <= m_rx_data;
            rsp_error <= m_ack_error;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end else if (tmo_hit) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Self-checking bench for i2c_cmd_queue: directed scenarios plus randomized command batches against a queue model.
module tb_i2c_cmd_queue;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int MR    = 2;
`ifdef I2C_RETRY_EN
  localparam int ATTEMPTS = MR + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic                      clock;
  logic                      reset;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [AW-1:0]             cmd_addr;
  logic [DW-1:0]             cmd_data;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DW-1:0]             rsp_data;
  logic                      rsp_error;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic                      idle;
  logic [AW-1:0]             m_slave_addr;
  logic [DW-1:0]             m_tx_data;
  logic                      m_ready;
  logic [DW-1:0]             m_rx_data;
  logic                      m_valid;
  logic                      m_busy;
  logic                      m_ack_error;

  i2c_cmd_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .fifo_count(fifo_count), .idle(idle),
    .m_slave_addr(m_slave_addr), .m_tx_data(m_tx_data), .m_ready(m_ready),
    .m_rx_data(m_rx_data), .m_valid(m_valid), .m_busy(m_busy), .m_ack_error(m_ack_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [AW+DW-1:0] model_q [$];
  logic [AW-1:0]    cur_a;
  logic [DW-1:0]    cur_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    model_q.push_back({a, d});
  endtask

  task automatic wait_issue(output int waited);
    waited = 0;
    while (!m_ready && waited < 30) begin
      tick();
      waited++;
    end
    chk("issue_seen", m_ready, 1);
    if (model_q.size() > 0) {cur_a, cur_d} = model_q.pop_front();
    chk("issue_addr", m_slave_addr, cur_a);
    chk("issue_data", m_tx_data, cur_d);
    chk("count_after_pop", fifo_count, model_q.size());
  endtask

  task automatic complete(input logic [DW-1:0] rx, input bit nack, input bit silent,
                          input int d, input int hold);
    int attempts;
    logic [DW-1:0] exp_data;
    bit exp_err;
    attempts = (nack || silent) ? ATTEMPTS : 1;
    exp_data = silent ? '0 : rx;
    exp_err  = nack || silent;
    for (int at = 0; at < attempts; at++) begin
      if (silent) begin
        repeat (TMO - 2) tick();
        chk("tmo_not_early", rsp_valid | m_ready, 0);
        tick();
      end else begin
        repeat (d) tick();
        m_valid     = 1'b1;
        m_rx_data   = rx;
        m_ack_error = nack;
        tick();
        m_valid     = 1'b0;
        m_ack_error = 1'b0;
        m_rx_data   = DW'($urandom);
      end
      if (at < attempts - 1) begin
        chk("retry_issue", m_ready, 1);
        chk("retry_addr", m_slave_addr, cur_a);
        chk("retry_data", m_tx_data, cur_d);
        tick();
        chk("retry_one_cycle", m_ready, 0);
      end
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_error", rsp_error, exp_err);
    chk("no_extra_issue", m_ready, 0);
    for (int h = 0; h < hold; h++) begin
      m_valid     = 1'b1;
      m_rx_data   = ~rx;
      m_ack_error = ~exp_err;
      tick();
      m_valid     = 1'b0;
      m_ack_error = 1'b0;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, exp_data);
      chk("hold_error", rsp_error, exp_err);
      chk("hold_no_issue", m_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_consumed", rsp_valid, 0);
  endtask

  task automatic serve(input logic [DW-1:0] rx, input bit nack, input bit silent,
                       input int d, input int hold);
    int w;
    wait_issue(w);
    tick();
    chk("issue_one_cycle", m_ready, 0);
    complete(rx, nack, silent, d, hold);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    bit nk;
    bit sl;
    bit seen;
    logic [AW-1:0] a5;
    logic [DW-1:0] d5;

    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_data    = '0;
    rsp_ready   = 1'b0;
    m_rx_data   = '0;
    m_valid     = 1'b0;
    m_busy      = 1'b0;
    m_ack_error = 1'b0;

    #3;
    chk("rst_count", fifo_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_addr", m_slave_addr, 0);
    chk("rst_tx", m_tx_data, 0);
    #10;
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Basic transfer with 2-cycle accept-to-m_ready latency
    push(7'h50, 8'hA5);
    chk("latency_pre", m_ready, 0);
    wait_issue(w);
    chk("latency", w, 1);
    tick();
    chk("issue_one_cycle", m_ready, 0);
    complete(8'h3C, 1'b0, 1'b0, 1, 2);
    chk("idle_after_basic", idle, 1);

    // Busy master holds the command in the FIFO
    m_busy = 1'b1;
    push(AW'($urandom), DW'($urandom));
    repeat (3) tick();
    chk("busy_no_issue", m_ready, 0);
    chk("busy_count", fifo_count, 1);
    m_busy = 1'b0;
    serve(DW'($urandom), 1'b0, 1'b0, 0, 0);

    // Silent master: timeout response
    push(AW'($urandom), DW'($urandom));
    serve(DW'($urandom), 1'b0, 1'b1, 0, 1);

    // Completion on the last possible cycle wins over the timeout
    push(AW'($urandom), DW'($urandom));
    serve(8'h96, 1'b0, 1'b0, TMO - 2, 0);

    // NACK on every attempt
    push(AW'($urandom), DW'($urandom));
    serve(8'h11, 1'b1, 1'b0, 2, 0);

    // Full FIFO back-pressure and order
    m_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(AW'($urandom), DW'($urandom));
    chk("full_count", fifo_count, DEPTH);
    chk("full_ready", cmd_ready, 0);
    a5 = AW'($urandom);
    d5 = DW'($urandom);
    cmd_addr  = a5;
    cmd_data  = d5;
    cmd_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("full_hold_count", fifo_count, DEPTH);
    end
    m_busy = 1'b0;
    tick();
    wait_issue(w);
    chk("full_pop_wait", w, 0);
    chk("full_pop_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    model_q.push_back({a5, d5});
    chk("refill_count", fifo_count, DEPTH);
    chk("refill_one_cycle", m_ready, 0);
    complete(DW'($urandom), 1'b0, 1'b0, $urandom_range(0, 4), 0);
    for (int i = 0; i < DEPTH; i++) serve(DW'($urandom), 1'b0, 1'b0, $urandom_range(0, 4), 0);
    chk("idle_after_full", idle, 1);

    // Push and pop on the same edge
    m_busy = 1'b1;
    push(AW'($urandom), DW'($urandom));
    push(AW'($urandom), DW'($urandom));
    chk("pp_pre_count", fifo_count, 2);
    a5 = AW'($urandom);
    d5 = DW'($urandom);
    cmd_addr  = a5;
    cmd_data  = d5;
    cmd_valid = 1'b1;
    m_busy    = 1'b0;
    model_q.push_back({a5, d5});
    tick();
    cmd_valid = 1'b0;
    wait_issue(w);
    chk("pp_same_edge", w, 0);
    tick();
    chk("pp_one_cycle", m_ready, 0);
    complete(DW'($urandom), 1'b0, 1'b0, 1, 0);
    serve(DW'($urandom), 1'b0, 1'b0, 0, 1);
    serve(DW'($urandom), 1'b0, 1'b0, 3, 0);
    chk("idle_after_pp", idle, 1);

    // Randomized batches
    for (int g = 0; g < 8; g++) begin
      m_busy = 1'b1;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) push(AW'($urandom), DW'($urandom));
      m_busy = 1'b0;
      for (int i = 0; i < n; i++) begin
        nk = ($urandom_range(0, 3) == 0);
        sl = !nk && ($urandom_range(0, 7) == 0);
        serve(DW'($urandom), nk, sl, $urandom_range(0, 6), $urandom_range(0, 2));
      end
      chk("batch_idle", idle, 1);
    end

    // Reset in WAIT_DONE with two commands queued
    m_busy = 1'b1;
    for (int i = 0; i < 3; i++) push(AW'($urandom), DW'($urandom));
    m_busy = 1'b0;
    wait_issue(w);
    tick();
    chk("mid_count", fifo_count, 2);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_m_ready", m_ready, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_addr", m_slave_addr, 0);
    model_q.delete();
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      m_valid   = (i % 3 == 0);
      m_rx_data = DW'($urandom);
      tick();
      if (rsp_valid || m_ready) seen = 1'b1;
    end
    m_valid = 1'b0;
    chk("post_reset_quiet", seen, 0);
    chk("post_reset_idle", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
